solver_dispatch_scheduler: RTL and testbench
============================================

// Module: solver_dispatch_scheduler
// PURPOSE
//  Schedules per-pixel escape-time jobs onto NUM_SOLVERS parallel solver cores and collects their results.
//  Accepts jobs (pixel id + c coordinate) on a valid/ready stream and starts the next idle solver, round-robin.
//  Arbitrates finished solvers, round-robin, onto a single result stream for the pixel writer.
//  Sits between the HPS-fed job source and the solver array, inside the solver manager, on CLOCK_50.
// PARAMETERS
//  NUM_SOLVERS    4   number of solver slots managed (1..32)
//  COORD_BITS     27  width of signed fixed-point cx/cy
//  ITER_BITS      10  width of iteration count and limit
//  PIXEL_ID_BITS  19  width of pixel id (640x480 linear address)
// PORTS
//  clock         in   1                      single clock; all logic on its rising edge
//  reset         in   1                      synchronous, active-high
//  abort         in   1                      synchronous flush of all jobs (view change)
//  max_iter      in   ITER_BITS              iteration limit; forwarded to solvers unchanged
//  job_valid     in   1                      job offered
//  job_ready     out  1                      job accepted when valid&&ready
//  job_pixel_id  in   PIXEL_ID_BITS          pixel id of the job
//  job_cx        in   COORD_BITS             signed real part of c
//  job_cy        in   COORD_BITS             signed imaginary part of c
//  solver_start  out  NUM_SOLVERS            one-cycle start pulse, one bit per solver
//  solver_cx     out  COORD_BITS             registered cx, valid while the start bit is high
//  solver_cy     out  COORD_BITS             registered cy, valid while the start bit is high
//  solver_limit  out  ITER_BITS              equals max_iter
//  solver_done   in   NUM_SOLVERS            one-cycle done pulse per solver
//  solver_iters  in   NUM_SOLVERS*ITER_BITS  flattened counts; slot i at [i*ITER_BITS +: ITER_BITS]
//  res_valid     out  1                      result held
//  res_ready     in   1                      consumer accepts the result
//  res_pixel_id  out  PIXEL_ID_BITS          pixel id of the result
//  res_iters     out  ITER_BITS              iteration count of the result
//  active_count  out  $clog2(NUM_SOLVERS+1)  number of slots not IDLE
//  proto_err     out  1                      sticky: done pulse seen on a slot that was not BUSY
// BEHAVIOUR
//  Reset values: all slots IDLE; both rr pointers 0.
//   Outputs at reset: solver_start=0, solver_cx/cy=0, res_valid=0, res_pixel_id=0, res_iters=0, active_count=0, proto_err=0.
//  Per-slot state: IDLE -> BUSY on dispatch; BUSY -> DONE on solver_done; DONE -> IDLE when its result is accepted.
//   Each slot stores its pixel id while BUSY and its iteration count while DONE.
//  job_ready is combinational: (any slot IDLE) && !reset && !abort. It uses only pre-edge state.
//   A slot freed on edge e is dispatchable from cycle e+1.
//  Dispatch on edge t (job_valid&&job_ready):
//   - the first IDLE slot at or after the dispatch rr pointer, with wrap-around, goes BUSY;
//   - solver_start[slot]=1 with solver_cx/cy for exactly the cycle after t;
//   - the dispatch rr pointer becomes (slot+1) mod NUM_SOLVERS.
//   At most one dispatch per cycle.
//  Done sampling: solver_done[i] is taken only when slot i is BUSY and solver_start[i] is 0.
//   The slot then goes DONE and latches its iters slice.
//   Otherwise the pulse is ignored and proto_err is set.
//  Result output register, loaded when (!res_valid || res_ready):
//   - the first DONE slot at or after the collect rr pointer is loaded into res_*; res_valid=1;
//   - if no slot is DONE, res_valid=0.
//   A loaded slot goes IDLE on the edge its result is accepted.
//   The collect pointer advances to (slot+1) mod NUM_SOLVERS.
//   Back-to-back results are sustained at 1 per cycle while res_ready=1.
//  Stall: res_* hold stable while res_valid && !res_ready.
//  Latency: done sampled at edge e -> res_valid high after edge e+1.
//  Simultaneous events: dispatch, several done pulses and a result accept may occur on the same edge.
//   All are applied; the slot sets involved are disjoint by construction.
//  abort: same effect as reset, except proto_err and max_iter forwarding are kept.
//   solver_start is held 0 while abort is high.
//   Solvers keep running; done pulses arriving after abort hit IDLE slots and are ignored without setting proto_err.
//   This applies only for the 2^ITER_BITS+2 cycles after abort deasserts, counted by an internal window counter.
//  Full: all slots non-IDLE -> job_ready=0. Empty: all slots IDLE and !res_valid -> active_count=0.
// STRUCTURE
//  Shared header solver_defs.vh: slot-state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and default widths.
//   The same header is used by the solver manager and the pixel writer.
//  Sub-module rr_pick #(N): combinational round-robin first-set finder (request vector, pointer -> one-hot grant, index, any).
//   Instantiated twice: once for dispatch (over IDLE) and once for collect (over DONE).
// TESTING
//  1. N=4, res_ready=1; 4 jobs ids 0..3 back-to-back -> starts on slots 0,1,2,3 in consecutive cycles;
//     job_ready=0 after the 4th; active_count=4.
//  2. Slots 2 and 0 pulse done on the same cycle with iters 7 and 9 -> results (id2,7) then (id0,9) on consecutive cycles.
//     Collect pointer was 1, so slot 2 comes first.
//  3. res_ready=0 for 10 cycles with 3 slots DONE -> res_* stable (id, iters) throughout; no slot freed; job_ready=0 if the 4th is BUSY.
//  4. Result accept and new job_valid on the same edge -> job is rejected that cycle and accepted next cycle into the freed slot.
//  5. abort with 3 BUSY slots and res_valid=1 -> next cycle res_valid=0, active_count=0;
//     later stale done pulses produce no result and proto_err stays 0.
//  6. solver_done[1] while slot 1 IDLE (no abort window) -> proto_err=1 and stays set until reset; no result emitted.

Source files
------------

// File: rtl/solver_dispatch_scheduler_pkg.sv
// Shared definitions for the solver manager: slot-state encoding and default widths.
package solver_dispatch_scheduler_pkg;

  typedef enum logic [1:0] {
    SlotIdle = 2'd0,
    SlotBusy = 2'd1,
    SlotDone = 2'd2
  } slot_state_e;

  localparam int unsigned DefNumSolvers  = 4;
  localparam int unsigned DefCoordBits   = 27;
  localparam int unsigned DefIterBits    = 10;
  localparam int unsigned DefPixelIdBits = 19;

  // Index width that stays legal for a single-entry vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/solver_dispatch_scheduler_rr_pick.sv
// Combinational round-robin first-set finder: first request at or after ptr, with wrap-around.
module solver_dispatch_scheduler_rr_pick
  import solver_dispatch_scheduler_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = idx_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  int unsigned     pos;
  logic [IdxW-1:0] pos_idx;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    any     = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= N) pos = pos - N;
      pos_idx = IdxW'(pos);
      if (!any && req[pos_idx]) begin
        any          = 1'b1;
        gnt[pos_idx] = 1'b1;
        idx          = pos_idx;
      end
    end
  end

endmodule

// File: rtl/solver_dispatch_scheduler.sv
// Dispatches escape-time jobs onto idle solver slots and collects finished results,
// both round-robin, with a one-deep result register toward the pixel writer.
module solver_dispatch_scheduler
  import solver_dispatch_scheduler_pkg::*;
#(
  parameter int unsigned NUM_SOLVERS   = DefNumSolvers,
  parameter int unsigned COORD_BITS    = DefCoordBits,
  parameter int unsigned ITER_BITS     = DefIterBits,
  parameter int unsigned PIXEL_ID_BITS = DefPixelIdBits
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             abort,
  input  logic [ITER_BITS-1:0]             max_iter,
  input  logic                             job_valid,
  output logic                             job_ready,
  input  logic [PIXEL_ID_BITS-1:0]         job_pixel_id,
  input  logic [COORD_BITS-1:0]            job_cx,
  input  logic [COORD_BITS-1:0]            job_cy,
  output logic [NUM_SOLVERS-1:0]           solver_start,
  output logic [COORD_BITS-1:0]            solver_cx,
  output logic [COORD_BITS-1:0]            solver_cy,
  output logic [ITER_BITS-1:0]             solver_limit,
  input  logic [NUM_SOLVERS-1:0]           solver_done,
  input  logic [NUM_SOLVERS*ITER_BITS-1:0] solver_iters,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [PIXEL_ID_BITS-1:0]         res_pixel_id,
  output logic [ITER_BITS-1:0]             res_iters,
  output logic [$clog2(NUM_SOLVERS+1)-1:0] active_count,
  output logic                             proto_err
);

  localparam int unsigned     IdxW   = idx_width(NUM_SOLVERS);
  localparam int unsigned     CntW   = $clog2(NUM_SOLVERS + 1);
  localparam int unsigned     WinW   = ITER_BITS + 2;
  localparam logic [WinW-1:0] WinLen = WinW'((1 << ITER_BITS) + 2);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_SOLVERS - 1);

  slot_state_e              state_q [NUM_SOLVERS];
  slot_state_e              state_d [NUM_SOLVERS];
  logic [PIXEL_ID_BITS-1:0] pix_q   [NUM_SOLVERS];
  logic [PIXEL_ID_BITS-1:0] pix_d   [NUM_SOLVERS];
  logic [ITER_BITS-1:0]     iters_q [NUM_SOLVERS];
  logic [ITER_BITS-1:0]     iters_d [NUM_SOLVERS];

  logic [IdxW-1:0]          disp_ptr_q, disp_ptr_d, coll_ptr_q, coll_ptr_d;
  logic [NUM_SOLVERS-1:0]   start_q, start_d;
  logic [COORD_BITS-1:0]    cx_q, cx_d, cy_q, cy_d;
  logic                     res_valid_q, res_valid_d;
  logic [PIXEL_ID_BITS-1:0] res_pix_q, res_pix_d;
  logic [ITER_BITS-1:0]     res_iters_q, res_iters_d;
  // One-hot of the slot whose result currently sits in the output register.
  logic [NUM_SOLVERS-1:0]   loaded_q, loaded_d;
  logic                     proto_err_q, proto_err_d;
  logic [WinW-1:0]          win_q;

  logic [NUM_SOLVERS-1:0]   idle_vec, coll_req, disp_gnt, coll_gnt;
  logic [IdxW-1:0]          disp_idx, coll_idx;
  logic                     disp_any, coll_any;
  logic                     dispatch, accept, load, stale_ok;

  always_comb begin
    for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
      idle_vec[i] = (state_q[i] == SlotIdle);
      coll_req[i] = (state_q[i] == SlotDone) && !loaded_q[i];
    end
  end

  solver_dispatch_scheduler_rr_pick #(
    .N    (NUM_SOLVERS),
    .IdxW (IdxW)
  ) u_disp_pick (
    .req (idle_vec),
    .ptr (disp_ptr_q),
    .gnt (disp_gnt),
    .idx (disp_idx),
    .any (disp_any)
  );

  solver_dispatch_scheduler_rr_pick #(
    .N    (NUM_SOLVERS),
    .IdxW (IdxW)
  ) u_coll_pick (
    .req (coll_req),
    .ptr (coll_ptr_q),
    .gnt (coll_gnt),
    .idx (coll_idx),
    .any (coll_any)
  );

  assign dispatch = job_valid && job_ready;
  assign accept   = res_valid_q && res_ready;
  assign load     = !res_valid_q || res_ready;
  // Done pulses from solvers still finishing pre-abort work land on idle slots.
  assign stale_ok = abort || (win_q != '0);

  // Next-state logic: slot FSMs, pointers, start/coordinate and result registers.
  always_comb begin
    proto_err_d = proto_err_q;
    disp_ptr_d  = disp_ptr_q;
    coll_ptr_d  = coll_ptr_q;
    start_d     = '0;
    cx_d        = cx_q;
    cy_d        = cy_q;
    res_valid_d = res_valid_q;
    res_pix_d   = res_pix_q;
    res_iters_d = res_iters_q;
    loaded_d    = loaded_q;

    for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
      state_d[i] = state_q[i];
      pix_d[i]   = pix_q[i];
      iters_d[i] = iters_q[i];
      if (dispatch && disp_gnt[i]) begin
        state_d[i] = SlotBusy;
        pix_d[i]   = job_pixel_id;
      end
      if (solver_done[i]) begin
        if (state_q[i] == SlotBusy && !start_q[i]) begin
          state_d[i] = SlotDone;
          iters_d[i] = solver_iters[i*ITER_BITS +: ITER_BITS];
        end else if (!(stale_ok && state_q[i] == SlotIdle)) begin
          proto_err_d = 1'b1;
        end
      end
      if (accept && loaded_q[i]) state_d[i] = SlotIdle;
    end

    if (dispatch) begin
      start_d    = disp_gnt;
      cx_d       = job_cx;
      cy_d       = job_cy;
      disp_ptr_d = (disp_idx == LastIdx) ? '0 : disp_idx + IdxW'(1);
    end

    if (load) begin
      res_valid_d = coll_any;
      loaded_d    = coll_gnt;
      if (coll_any) begin
        res_pix_d   = pix_q[coll_idx];
        res_iters_d = iters_q[coll_idx];
        coll_ptr_d  = (coll_idx == LastIdx) ? '0 : coll_idx + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || abort) begin
      for (int unsigned i = 0; i < NUM_SOLVERS; i++) state_q[i] <= SlotIdle;
      disp_ptr_q  <= '0;
      coll_ptr_q  <= '0;
      start_q     <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      res_valid_q <= 1'b0;
      res_pix_q   <= '0;
      res_iters_q <= '0;
      loaded_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SOLVERS; i++) state_q[i] <= state_d[i];
      disp_ptr_q  <= disp_ptr_d;
      coll_ptr_q  <= coll_ptr_d;
      start_q     <= start_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      res_valid_q <= res_valid_d;
      res_pix_q   <= res_pix_d;
      res_iters_q <= res_iters_d;
      loaded_q    <= loaded_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
        pix_q[i]   <= '0;
        iters_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
        pix_q[i]   <= pix_d[i];
        iters_q[i] <= iters_d[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      proto_err_q <= 1'b0;
      win_q       <= '0;
    end else begin
      proto_err_q <= proto_err_d;
      if (abort)             win_q <= WinLen;
      else if (win_q != '0)  win_q <= win_q - WinW'(1);
    end
  end

  // Output logic.
  always_comb begin
    job_ready    = disp_any && !reset && !abort;
    active_count = '0;
    for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
      if (!idle_vec[i]) active_count = active_count + CntW'(1);
    end
  end

  assign solver_start = start_q;
  assign solver_cx    = cx_q;
  assign solver_cy    = cy_q;
  assign solver_limit = max_iter;
  assign res_valid    = res_valid_q;
  assign res_pixel_id = res_pix_q;
  assign res_iters    = res_iters_q;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_solver_dispatch_scheduler.sv
// Directed bench for solver_dispatch_scheduler: dispatch, collect, stall, abort and protocol error.
module tb_solver_dispatch_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned CB = 27;
  localparam int unsigned IB = 10;
  localparam int unsigned PB = 19;

  logic          clock = 1'b0;
  logic          reset, abort, job_valid, res_ready;
  logic [IB-1:0] max_iter;
  logic          job_ready;
  logic [PB-1:0] job_pixel_id;
  logic [CB-1:0] job_cx, job_cy;
  logic [N-1:0]  solver_start, solver_done;
  logic [CB-1:0] solver_cx, solver_cy;
  logic [IB-1:0] solver_limit;
  logic [N*IB-1:0] solver_iters;
  logic          res_valid;
  logic [PB-1:0] res_pixel_id;
  logic [IB-1:0] res_iters;
  logic [2:0]    active_count;
  logic          proto_err;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  solver_dispatch_scheduler #(
    .NUM_SOLVERS   (N),
    .COORD_BITS    (CB),
    .ITER_BITS     (IB),
    .PIXEL_ID_BITS (PB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .abort        (abort),
    .max_iter     (max_iter),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_pixel_id (job_pixel_id),
    .job_cx       (job_cx),
    .job_cy       (job_cy),
    .solver_start (solver_start),
    .solver_cx    (solver_cx),
    .solver_cy    (solver_cy),
    .solver_limit (solver_limit),
    .solver_done  (solver_done),
    .solver_iters (solver_iters),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_pixel_id (res_pixel_id),
    .res_iters    (res_iters),
    .active_count (active_count),
    .proto_err    (proto_err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int id, input int it);
    chk({tag, ".valid"}, 64'(res_valid), 64'd1);
    chk({tag, ".id"}, 64'(res_pixel_id), 64'(id));
    chk({tag, ".iters"}, 64'(res_iters), 64'(it));
  endtask

  task automatic offer(input int id);
    job_valid    = 1'b1;
    job_pixel_id = PB'(id);
    job_cx       = CB'(100 + id);
    job_cy       = CB'(200 + id);
  endtask

  task automatic done_pulse(input logic [N-1:0] mask, input int i0, input int i1,
                            input int i2, input int i3);
    solver_done              = mask;
    solver_iters[0*IB +: IB] = IB'(i0);
    solver_iters[1*IB +: IB] = IB'(i1);
    solver_iters[2*IB +: IB] = IB'(i2);
    solver_iters[3*IB +: IB] = IB'(i3);
    tick();
    solver_done = '0;
  endtask

  initial begin
    reset = 1'b1; abort = 1'b0; job_valid = 1'b0; res_ready = 1'b1;
    max_iter = 10'd100; job_pixel_id = '0; job_cx = '0; job_cy = '0;
    solver_done = '0; solver_iters = '0;
    tick();
    tick();
    // Reset state.
    chk("rst.start", 64'(solver_start), 64'd0);
    chk("rst.cx", 64'(solver_cx), 64'd0);
    chk("rst.cy", 64'(solver_cy), 64'd0);
    chk("rst.res_valid", 64'(res_valid), 64'd0);
    chk("rst.res_id", 64'(res_pixel_id), 64'd0);
    chk("rst.res_iters", 64'(res_iters), 64'd0);
    chk("rst.active", 64'(active_count), 64'd0);
    chk("rst.proto_err", 64'(proto_err), 64'd0);
    chk("rst.job_ready", 64'(job_ready), 64'd0);
    chk("limit.100", 64'(solver_limit), 64'd100);
    reset = 1'b0;
    #1;
    chk("idle.job_ready", 64'(job_ready), 64'd1);

    // 1. Four jobs back-to-back fill slots 0..3.
    for (int k = 0; k < 4; k++) begin
      offer(k);
      #1;
      chk("t1.ready", 64'(job_ready), 64'd1);
      tick();
      chk("t1.start", 64'(solver_start), 64'(1 << k));
      chk("t1.cx", 64'(solver_cx), 64'(100 + k));
      chk("t1.cy", 64'(solver_cy), 64'(200 + k));
    end
    job_valid = 1'b0;
    #1;
    chk("t1.full_ready", 64'(job_ready), 64'd0);
    chk("t1.active", 64'(active_count), 64'd4);
    tick();
    chk("t1.start_clr", 64'(solver_start), 64'd0);

    // Slot 0 finishes alone so the collect pointer moves to 1.
    done_pulse(4'b0001, 5, 0, 0, 0);
    chk("t2a.latency", 64'(res_valid), 64'd0);
    tick();
    chk_res("t2a", 0, 5);
    tick();
    chk("t2a.drained", 64'(res_valid), 64'd0);
    chk("t2a.active", 64'(active_count), 64'd3);
    offer(4);
    tick();
    job_valid = 1'b0;
    chk("t2a.start", 64'(solver_start), 64'b0001);
    tick();

    // 2. Slots 2 and 0 done together; pointer 1 puts slot 2 first.
    done_pulse(4'b0101, 9, 0, 7, 0);
    chk("t2.latency", 64'(res_valid), 64'd0);
    tick();
    chk_res("t2.first", 2, 7);
    tick();
    chk_res("t2.second", 4, 9);
    tick();
    chk("t2.drained", 64'(res_valid), 64'd0);
    chk("t2.active", 64'(active_count), 64'd2);

    // 3. Refill slots 2 and 0, then stall three results behind res_ready=0.
    offer(5);
    tick();
    chk("t3.start5", 64'(solver_start), 64'b0100);
    offer(6);
    tick();
    chk("t3.start6", 64'(solver_start), 64'b0001);
    job_valid = 1'b0;
    #1;
    chk("t3.full", 64'(job_ready), 64'd0);
    tick();
    res_ready = 1'b0;
    done_pulse(4'b1110, 0, 11, 12, 13);
    tick();
    for (int k = 0; k < 10; k++) begin
      chk_res("t3.stall", 1, 11);
      chk("t3.active", 64'(active_count), 64'd4);
      chk("t3.ready", 64'(job_ready), 64'd0);
      tick();
    end

    // 4. Accept and job offer on the same edge: job waits one cycle.
    res_ready = 1'b1;
    offer(7);
    #1;
    chk("t4.ready_pre", 64'(job_ready), 64'd0);
    tick();
    chk("t4.no_start", 64'(solver_start), 64'd0);
    chk_res("t4.next", 5, 12);
    chk("t4.ready_post", 64'(job_ready), 64'd1);
    tick();
    chk("t4.start", 64'(solver_start), 64'b0010);
    chk("t4.cx", 64'(solver_cx), 64'd107);
    chk_res("t4.next2", 3, 13);
    res_ready = 1'b0;
    offer(8);
    tick();
    job_valid = 1'b0;
    chk("t4.start8", 64'(solver_start), 64'b0100);
    chk_res("t4.held", 3, 13);

    // 5. Abort with three busy slots and a held result.
    abort = 1'b1;
    #1;
    chk("t5.ready_abort", 64'(job_ready), 64'd0);
    tick();
    abort = 1'b0;
    chk("t5.res_valid", 64'(res_valid), 64'd0);
    chk("t5.active", 64'(active_count), 64'd0);
    chk("t5.start", 64'(solver_start), 64'd0);
    chk("t5.res_id", 64'(res_pixel_id), 64'd0);
    chk("t5.res_iters", 64'(res_iters), 64'd0);
    res_ready = 1'b1;
    #1;
    chk("t5.ready", 64'(job_ready), 64'd1);
    done_pulse(4'b1111, 1, 2, 3, 4);
    tick();
    tick();
    chk("t5.stale_res", 64'(res_valid), 64'd0);
    chk("t5.stale_err", 64'(proto_err), 64'd0);
    chk("t5.stale_active", 64'(active_count), 64'd0);
    offer(9);
    tick();
    job_valid = 1'b0;
    chk("t5.start9", 64'(solver_start), 64'b0001);
    tick();
    done_pulse(4'b0001, 20, 0, 0, 0);
    tick();
    chk_res("t5.res9", 9, 20);
    tick();
    chk("t5.drained", 64'(res_valid), 64'd0);
    chk("t5.active0", 64'(active_count), 64'd0);

    // 6. Done on an idle slot once the abort window has expired.
    repeat (1100) tick();
    chk("t6.err_pre", 64'(proto_err), 64'd0);
    done_pulse(4'b0010, 0, 33, 0, 0);
    chk("t6.err", 64'(proto_err), 64'd1);
    tick();
    tick();
    chk("t6.no_res", 64'(res_valid), 64'd0);
    chk("t6.active", 64'(active_count), 64'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("t6.sticky", 64'(proto_err), 64'd1);
    max_iter = 10'd500;
    #1;
    chk("limit.500", 64'(solver_limit), 64'd500);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6.cleared", 64'(proto_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
